// File: rtl/tenyr_pkg.sv
// Shared definitions for the tenyr execute pipeline: opcode encodings and
// the iterative-multiply control states.
package tenyr_pkg;

   localparam logic [3:0] OP_OR   = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_RSVD = 4'b0100;
   localparam logic [3:0] OP_SHL  = 4'h5;
   localparam logic [3:0] OP_LE   = 4'h6;
   localparam logic [3:0] OP_EQ   = 4'h7;
   localparam logic [3:0] OP_NOR  = 4'h8;
   localparam logic [3:0] OP_NAND = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_XNOR = 4'hC;
   localparam logic [3:0] OP_SHR  = 4'hD;
   localparam logic [3:0] OP_GT   = 4'hE;
   localparam logic [3:0] OP_NE   = 4'hF;

   // IDLE accepts new work, RUN iterates the multiplier, HOLD parks a
   // finished product until the pipeline can take it.
   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_RUN,
      MUL_HOLD
   } mul_state_e;

endpackage

// File: rtl/tenyr_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// The product is available combinationally on the final step (done) and
// stays stable on product afterwards until the next start.
module tenyr_mul_iter #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / MUL_STEP;
   localparam int CW = $clog2(STEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   logic             running_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] acc_next;

   assign partial  = mcand_q * WIDTH'(mplier_q[MUL_STEP-1:0]);
   assign acc_next = acc_q + partial;
   assign done     = running_q && (count_q == LAST);
   assign product  = running_q ? acc_next : acc_q;

   // Load operands on start, then fold one digit of the multiplier per cycle.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         running_q <= 1'b0;
         count_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
      end else if (start) begin
         running_q <= 1'b1;
         count_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= a;
         mplier_q  <= b;
      end else if (running_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << MUL_STEP;
         mplier_q <= mplier_q >> MUL_STEP;
         count_q  <= count_q + 1'b1;
         if (done) begin
            running_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tenyr_exec_pipe.sv
// tenyr execute unit: computes (X op O) + A through a STAGES-deep result
// pipeline with valid/ready on both sides. Multiplies run on an iterative
// multiplier while the input side is closed, keeping results in order.
// reset_n is asserted high.
module tenyr_exec_pipe
   import tenyr_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 12,
   parameter int STAGES    = 2,
   parameter int MUL_STEP  = 4,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic                 in_type,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   input  logic [IMM_WIDTH-1:0] in_imm,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_rhs,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_illegal,
   output logic                 busy
);

   typedef struct packed {
      logic                 valid;
      logic [WIDTH-1:0]     rhs;
      logic [TAG_WIDTH-1:0] tag;
      logic                 illegal;
   } stage_t;

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   stage_t               stage_q [1:STAGES];
   stage_t               s1_d;
   mul_state_e           state_q;
   mul_state_e           state_d;
   logic                 advance;
   logic                 accept;
   logic                 is_mul;
   logic                 mul_start;
   logic                 mul_done;
   logic [WIDTH-1:0]     mul_product;
   logic [WIDTH-1:0]     mul_a_q;
   logic [TAG_WIDTH-1:0] mul_tag_q;
   logic [WIDTH-1:0]     imm_ext;
   logic [WIDTH-1:0]     opnd_o;
   logic [WIDTH-1:0]     opnd_a;
   logic [WIDTH-1:0]     func;
   logic [WIDTH-1:0]     alu_rhs;

   assign advance   = !stage_q[STAGES].valid || out_ready;
   assign in_ready  = advance && (state_q == MUL_IDLE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (in_op == OP_MUL);
   assign mul_start = accept && is_mul;
   assign busy      = (state_q != MUL_IDLE);

   assign imm_ext = {{(WIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};
   assign opnd_o  = in_type ? imm_ext : in_y;
   assign opnd_a  = in_type ? in_y : imm_ext;

   assign out_valid   = stage_q[STAGES].valid;
   assign out_rhs     = stage_q[STAGES].rhs;
   assign out_tag     = stage_q[STAGES].tag;
   assign out_illegal = stage_q[STAGES].illegal;

   tenyr_mul_iter #(
      .WIDTH   (WIDTH),
      .MUL_STEP(MUL_STEP)
   ) u_mul (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (mul_start),
      .a      (in_x),
      .b      (opnd_o),
      .done   (mul_done),
      .product(mul_product)
   );

   // Single-cycle ALU: the X op O term, then A added except for the reserved op.
   always_comb begin
      func = '0;
      case (in_op)
         OP_OR:   func = in_x | opnd_o;
         OP_AND:  func = in_x & opnd_o;
         OP_ADD:  func = in_x + opnd_o;
         OP_SHL:  func = (opnd_o < WIDTH_V) ? (in_x << opnd_o) : '0;
         OP_LE:   func = ($signed(in_x) <= $signed(opnd_o)) ? '1 : '0;
         OP_EQ:   func = (in_x == opnd_o) ? '1 : '0;
         OP_NOR:  func = ~(in_x | opnd_o);
         OP_NAND: func = ~(in_x & opnd_o);
         OP_XOR:  func = in_x ^ opnd_o;
         OP_SUB:  func = in_x - opnd_o;
         OP_XNOR: func = in_x ^ ~opnd_o;
         OP_SHR:  func = (opnd_o < WIDTH_V) ? (in_x >> opnd_o) : '0;
         OP_GT:   func = ($signed(in_x) > $signed(opnd_o)) ? '1 : '0;
         OP_NE:   func = (in_x != opnd_o) ? '1 : '0;
         default: func = '0;
      endcase
      alu_rhs = (in_op == OP_RSVD) ? '0 : func + opnd_a;
   end

   // Multiply FSM next state and the record offered to S1 on the next advance.
   always_comb begin
      state_d = state_q;
      s1_d    = '0;
      case (state_q)
         MUL_IDLE: begin
            if (accept && !is_mul) begin
               s1_d.valid   = 1'b1;
               s1_d.rhs     = alu_rhs;
               s1_d.tag     = in_tag;
               s1_d.illegal = (in_op == OP_RSVD);
            end
            if (mul_start) begin
               state_d = MUL_RUN;
            end
         end
         MUL_RUN: begin
            if (mul_done) begin
               s1_d.valid = 1'b1;
               s1_d.rhs   = mul_product + mul_a_q;
               s1_d.tag   = mul_tag_q;
               state_d    = advance ? MUL_IDLE : MUL_HOLD;
            end
         end
         MUL_HOLD: begin
            s1_d.valid = 1'b1;
            s1_d.rhs   = mul_product + mul_a_q;
            s1_d.tag   = mul_tag_q;
            if (advance) begin
               state_d = MUL_IDLE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   // FSM state plus the A operand and tag that ride alongside a multiply.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q   <= MUL_IDLE;
         mul_a_q   <= '0;
         mul_tag_q <= '0;
      end else begin
         state_q <= state_d;
         if (mul_start) begin
            mul_a_q   <= opnd_a;
            mul_tag_q <= in_tag;
         end
      end
   end

   // Result pipeline: every stage shifts together on advance, all hold otherwise.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         for (int k = 1; k <= STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else if (advance) begin
         stage_q[1] <= s1_d;
         for (int k = 2; k <= STAGES; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

endmodule
